wishbone_arbiter_n: RTL and testbench

- N-master to 1-slave Wishbone arbiter; parametrised successor of the two-port wishbone_arbiter.
- Replaces cascaded 2:1 arbiter trees between caches and the inner bus with a single block.
- Adds selectable fixed-priority or round-robin arbitration, burst-aware ownership hold, and a per-transfer watchdog that aborts a hung slave with an error.
- Sits between the icache/dcache Wishbone masters and the inner Wishbone output.

---
 rtl/wishbone_arbiter_n_pkg.sv | 14 +
 rtl/wishbone_arbiter_n_rr_prio_select.sv | 37 +++
 rtl/wishbone_arbiter_n.sv | 165 ++++++++++++++++
 tb/tb_wishbone_arbiter_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_arbiter_n_pkg.sv
// Shared types and defaults for the N-master Wishbone arbiter.
package wishbone_arbiter_n_pkg;

  localparam int WB_DEF_AW = 24;
  localparam int WB_DEF_DW = 16;
  localparam int WB_DEF_SW = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wishbone_arbiter_n_rr_prio_select.sv
// Combinational requester select: rotate the request vector so the search
// starts at bit 0, take the lowest set bit, then rotate the index back.
module rr_prio_select #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          rr_mode,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             start;
  int             idx;
  int             sum;

  assign req_dbl = {req, req};

  // Round-robin starts one past the last owner; fixed priority starts at 0.
  always_comb begin
    start = 0;
    if (rr_mode) start = (int'(last) + 1) % N;
    req_rot = req_dbl[start +: N];
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) idx = i;
    end
    sum = start + idx;
    if (sum >= N) sum = sum - N;
    winner = IW'(sum);
    valid  = |req;
  end

endmodule

// File: rtl/wishbone_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter with round-robin or fixed priority,
// burst-safe ownership hold and a per-transfer watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner, slave bus quiet, arbitrating pending cyc requests
// ST_BUSY  | owner's signals muxed to the slave until owner drops cyc
// ST_ABORT | watchdog fired; bus quiet, waiting for owner to drop cyc
module wishbone_arbiter_n
  import wishbone_arbiter_n_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int AW      = WB_DEF_AW,
  parameter int DW      = WB_DEF_DW,
  parameter int SW      = WB_DEF_SW,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_M-1:0]         i_m_cyc,
  input  logic [NUM_M-1:0]         i_m_stb,
  input  logic [NUM_M-1:0]         i_m_we,
  input  logic [NUM_M*AW-1:0]      i_m_adr,
  input  logic [NUM_M*DW-1:0]      i_m_dat,
  input  logic [NUM_M*SW-1:0]      i_m_sel,
  input  logic [NUM_M-1:0]         i_m_4_burst,
  input  logic [NUM_M-1:0]         i_m_8_burst,
  output logic [NUM_M-1:0]         o_m_ack,
  output logic [NUM_M-1:0]         o_m_err,
  output logic [DW-1:0]            o_m_dat,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [AW-1:0]            o_wb_adr,
  output logic [DW-1:0]            o_wb_dat,
  output logic [SW-1:0]            o_wb_sel,
  output logic                     o_wb_4_burst,
  output logic                     o_wb_8_burst,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [DW-1:0]            i_wb_dat,
  output logic [$clog2(NUM_M)-1:0] o_owner
);

  localparam int   OW     = $clog2(NUM_M);
  localparam int   CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic RR_BIT = (RR_MODE != 0);

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          abort_first_q, abort_first_d;
  logic [OW-1:0] sel_idx;
  logic          sel_valid;
  logic          own_cyc;
  logic          own_stb;
  logic          wd_stall;

  rr_prio_select #(
    .N  (NUM_M),
    .IW (OW)
  ) u_sel (
    .req     (i_m_cyc),
    .last    (last_q),
    .rr_mode (RR_BIT),
    .winner  (sel_idx),
    .valid   (sel_valid)
  );

  // stb is only meaningful inside the owner's cycle, so gate it with cyc.
  assign own_cyc  = i_m_cyc[owner_q];
  assign own_stb  = own_cyc & i_m_stb[owner_q];
  assign wd_stall = own_stb & ~i_wb_ack & ~i_wb_err;

  // State, ownership and watchdog registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_q        <= OW'(NUM_M - 1);
      wd_cnt_q      <= '0;
      abort_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      wd_cnt_q      <= wd_cnt_d;
      abort_first_q <= abort_first_d;
    end
  end

  // Next-state logic: grant from IDLE, hold while owner cyc stays high,
  // abort once the owner has strobed TIMEOUT cycles with no response.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wd_cnt_d      = '0;
    abort_first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else if ((TIMEOUT > 0) && wd_stall) begin
          if (int'(wd_cnt_q) >= TIMEOUT - 1) begin
            wd_cnt_d      = CW'(TIMEOUT);
            abort_first_d = 1'b1;
            state_d       = ST_ABORT;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slave-side mux and master responses; cyc follows the BUSY state so a
  // granted master that already dropped cyc still shows one bus cycle.
  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_adr     = '0;
    o_wb_dat     = '0;
    o_wb_sel     = '0;
    o_wb_4_burst = 1'b0;
    o_wb_8_burst = 1'b0;
    o_m_ack      = '0;
    o_m_err      = '0;
    if (state_q == ST_BUSY) begin
      o_wb_cyc         = 1'b1;
      o_wb_stb         = own_stb;
      o_wb_we          = i_m_we[owner_q];
      o_wb_adr         = i_m_adr[owner_q*AW +: AW];
      o_wb_dat         = i_m_dat[owner_q*DW +: DW];
      o_wb_sel         = i_m_sel[owner_q*SW +: SW];
      o_wb_4_burst     = i_m_4_burst[owner_q];
      o_wb_8_burst     = i_m_8_burst[owner_q];
      o_m_ack[owner_q] = i_wb_ack;
      o_m_err[owner_q] = i_wb_err;
    end else if ((state_q == ST_ABORT) && abort_first_q) begin
      o_m_err[owner_q] = 1'b1;
    end
  end

  assign o_m_dat = i_wb_dat;
  assign o_owner = owner_q;

endmodule

// File: tb/tb_wishbone_arbiter_n.sv
// Directed bench for wishbone_arbiter_n: a round-robin instance and a
// fixed-priority instance share the same master and slave stimulus.
module tb_wishbone_arbiter_n;

  localparam int NM = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [NM-1:0]  m_cyc, m_stb, m_we, m_b4, m_b8;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic           wb_ack, wb_err;
  logic [DW-1:0]  wb_dat;

  logic [NM-1:0]  rr_m_ack, rr_m_err, fp_m_ack, fp_m_err;
  logic [DW-1:0]  rr_m_dat, fp_m_dat, rr_wb_dat, fp_wb_dat;
  logic           rr_wb_cyc, rr_wb_stb, rr_wb_we, rr_wb_b4, rr_wb_b8;
  logic           fp_wb_cyc, fp_wb_stb, fp_wb_we, fp_wb_b4, fp_wb_b8;
  logic [AW-1:0]  rr_wb_adr, fp_wb_adr;
  logic [SW-1:0]  rr_wb_sel, fp_wb_sel;
  logic [1:0]     rr_owner, fp_owner;

  int n_cmp;
  int n_err;
  int exp_rr [6];

  wishbone_arbiter_n #(.NUM_M(NM), .AW(AW), .DW(DW), .SW(SW), .RR_MODE(1), .TIMEOUT(4)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr),
    .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_4_burst(m_b4), .i_m_8_burst(m_b8),
    .o_m_ack(rr_m_ack), .o_m_err(rr_m_err), .o_m_dat(rr_m_dat),
    .o_wb_cyc(rr_wb_cyc), .o_wb_stb(rr_wb_stb), .o_wb_we(rr_wb_we),
    .o_wb_adr(rr_wb_adr), .o_wb_dat(rr_wb_dat), .o_wb_sel(rr_wb_sel),
    .o_wb_4_burst(rr_wb_b4), .o_wb_8_burst(rr_wb_b8),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat),
    .o_owner(rr_owner)
  );

  wishbone_arbiter_n #(.NUM_M(NM), .AW(AW), .DW(DW), .SW(SW), .RR_MODE(0), .TIMEOUT(4)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr),
    .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_4_burst(m_b4), .i_m_8_burst(m_b8),
    .o_m_ack(fp_m_ack), .o_m_err(fp_m_err), .o_m_dat(fp_m_dat),
    .o_wb_cyc(fp_wb_cyc), .o_wb_stb(fp_wb_stb), .o_wb_we(fp_wb_we),
    .o_wb_adr(fp_wb_adr), .o_wb_dat(fp_wb_dat), .o_wb_sel(fp_wb_sel),
    .o_wb_4_burst(fp_wb_b4), .o_wb_8_burst(fp_wb_b8),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat),
    .o_owner(fp_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_adr[k*AW +: AW] = adr;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_b4 = '0; m_b8 = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    wb_dat = 16'hBEEF;
    #12;
    chk("rst_cyc",   32'(rr_wb_cyc), 32'h0);
    chk("rst_owner", 32'(rr_owner),  32'h0);
    chk("rst_ack",   32'(rr_m_ack),  32'h0);
    chk("rst_err",   32'(rr_m_err),  32'h0);
    chk("rst_adr",   32'(rr_wb_adr), 32'h0);
    chk("rst_fp_cyc", 32'(fp_wb_cyc), 32'h0);
    chk("mdat_pass", 32'(rr_m_dat),  32'hBEEF);
    tick();
    rst_n = 1'b1;

    // single master: master 2 alone
    set_m(2, 1'b1, 1'b1, 24'h000123);
    m_sel[5:4] = 2'b10; m_we[2] = 1'b1; m_dat[47:32] = 16'h5A5A;
    settle();
    chk("single_not_yet", 32'(rr_wb_cyc), 32'h0);
    tick();
    chk("single_cyc",   32'(rr_wb_cyc), 32'h1);
    chk("single_stb",   32'(rr_wb_stb), 32'h1);
    chk("single_adr",   32'(rr_wb_adr), 32'h000123);
    chk("single_owner", 32'(rr_owner),  32'h2);
    chk("single_we",    32'(rr_wb_we),  32'h1);
    chk("single_sel",   32'(rr_wb_sel), 32'h2);
    chk("single_dat",   32'(rr_wb_dat), 32'h5A5A);
    wb_ack = 1'b1;
    settle();
    chk("single_ack", 32'(rr_m_ack), 32'h4);
    chk("single_err_none", 32'(rr_m_err), 32'h0);
    tick();
    wb_ack = 1'b1; wb_err = 1'b1;
    settle();
    chk("both_ack", 32'(rr_m_ack), 32'h4);
    chk("both_err", 32'(rr_m_err), 32'h4);
    tick();
    wb_ack = 1'b0; wb_err = 1'b0;
    set_m(2, 1'b0, 1'b0, 24'h0); m_we[2] = 1'b0;
    tick();
    chk("single_release", 32'(rr_wb_cyc), 32'h0);

    // round-robin fairness: masters 0, 1, 3 keep requesting
    do_reset();
    set_m(0, 1'b1, 1'b1, 24'h10);
    set_m(1, 1'b1, 1'b1, 24'h11);
    set_m(3, 1'b1, 1'b1, 24'h13);
    exp_rr = '{0, 1, 3, 0, 1, 3};
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_grant", 32'(rr_owner), 32'(exp_rr[g]));
      chk("rr_cyc",   32'(rr_wb_cyc), 32'h1);
      chk("rr_adr",   32'(rr_wb_adr), 32'(24'h10 + 24'(exp_rr[g])));
      tick();
      chk("rr_hold",  32'(rr_owner), 32'(exp_rr[g]));
      set_m(exp_rr[g], 1'b0, 1'b0, 24'(24'h10 + 24'(exp_rr[g])));
      tick();
      chk("rr_gap",   32'(rr_wb_cyc), 32'h0);
      set_m(exp_rr[g], 1'b1, 1'b1, 24'(24'h10 + 24'(exp_rr[g])));
    end

    // fixed priority: masters 0 and 1 keep requesting
    do_reset();
    set_m(0, 1'b1, 1'b1, 24'h20);
    set_m(1, 1'b1, 1'b1, 24'h21);
    tick();
    chk("fp_grant0", 32'(fp_owner), 32'h0);
    chk("fp_cyc",    32'(fp_wb_cyc), 32'h1);
    tick();
    chk("fp_hold0",  32'(fp_owner), 32'h0);
    set_m(0, 1'b0, 1'b0, 24'h20);
    tick();
    chk("fp_gap",    32'(fp_wb_cyc), 32'h0);
    set_m(0, 1'b1, 1'b1, 24'h20);
    tick();
    chk("fp_regrant0", 32'(fp_owner), 32'h0);
    tick();
    set_m(0, 1'b0, 1'b0, 24'h20);
    tick();
    chk("fp_gap2",   32'(fp_wb_cyc), 32'h0);
    tick();
    chk("fp_grant1", 32'(fp_owner), 32'h1);
    chk("fp_adr1",   32'(fp_wb_adr), 32'h21);

    // 8-beat burst held against a mid-burst request
    do_reset();
    m_b8[1] = 1'b1;
    set_m(1, 1'b1, 1'b1, 24'h40);
    tick();
    chk("burst_owner0", 32'(rr_owner), 32'h1);
    chk("burst_b8",     32'(rr_wb_b8), 32'h1);
    chk("burst_b4",     32'(rr_wb_b4), 32'h0);
    wb_ack = 1'b1;
    for (int b = 0; b < 8; b++) begin
      settle();
      chk("burst_owner", 32'(rr_owner), 32'h1);
      chk("burst_ack",   32'(rr_m_ack), 32'h2);
      if (b == 2) set_m(0, 1'b1, 1'b1, 24'h50);
      tick();
    end
    wb_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 24'h40);
    m_b8[1] = 1'b0;
    settle();
    chk("burst_after8", 32'(rr_owner), 32'h1);
    chk("burst_no_ack0", 32'(rr_m_ack), 32'h0);
    tick();
    chk("burst_gap",   32'(rr_wb_cyc), 32'h0);
    tick();
    chk("burst_next",  32'(rr_owner),  32'h0);
    chk("burst_next_adr", 32'(rr_wb_adr), 32'h50);
    chk("burst_next_b8", 32'(rr_wb_b8), 32'h0);

    // watchdog: slave never answers
    do_reset();
    set_m(2, 1'b1, 1'b1, 24'h60);
    set_m(3, 1'b1, 1'b1, 24'h70);
    tick();
    chk("wd_owner", 32'(rr_owner), 32'h2);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("wd_busy_cyc", 32'(rr_wb_cyc), 32'h1);
      chk("wd_no_err",   32'(rr_m_err),  32'h0);
      tick();
    end
    settle();
    chk("wd_err_pulse", 32'(rr_m_err),  32'h4);
    chk("wd_abort_cyc", 32'(rr_wb_cyc), 32'h0);
    chk("wd_abort_stb", 32'(rr_wb_stb), 32'h0);
    tick();
    wb_ack = 1'b1;
    settle();
    chk("wd_err_once", 32'(rr_m_err),  32'h0);
    chk("wd_late_ack", 32'(rr_m_ack),  32'h0);
    chk("wd_abort_hold", 32'(rr_wb_cyc), 32'h0);
    set_m(2, 1'b0, 1'b0, 24'h60);
    wb_ack = 1'b0;
    tick();
    chk("wd_idle", 32'(rr_wb_cyc), 32'h0);
    tick();
    chk("wd_next_owner", 32'(rr_owner),  32'h3);
    chk("wd_next_cyc",   32'(rr_wb_cyc), 32'h1);

    // reset pulled during beat 3 of a burst
    do_reset();
    m_b8[1] = 1'b1;
    set_m(1, 1'b1, 1'b1, 24'h80);
    tick();
    wb_ack = 1'b1;
    tick();
    tick();
    settle();
    chk("rstmid_pre", 32'(rr_wb_cyc), 32'h1);
    rst_n = 1'b0;
    settle();
    chk("rstmid_cyc",   32'(rr_wb_cyc), 32'h0);
    chk("rstmid_owner", 32'(rr_owner),  32'h0);
    chk("rstmid_ack",   32'(rr_m_ack),  32'h0);
    chk("rstmid_err",   32'(rr_m_err),  32'h0);
    chk("rstmid_adr",   32'(rr_wb_adr), 32'h0);
    wb_ack = 1'b0;
    set_m(3, 1'b1, 1'b1, 24'h90);
    tick();
    chk("rstmid_held", 32'(rr_wb_cyc), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_regrant", 32'(rr_owner),  32'h1);
    chk("rstmid_recyc",   32'(rr_wb_cyc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
